// File: rtl/bist_session_sequencer.sv
// ---------------------------------------------------------------------------
// bist_session_sequencer
//
// Runs a complete STRAIT self-test session on its own. Steps through a
// programmable list of BIST phases, raising test_mode, pulsing START with the
// per-phase BIST_mode code, then waiting for a rising edge of test_done.
// Per-phase fail flags are made sticky. A watchdog catches hung phases, and
// the whole enabled list is repeated repeat_cfg times.
//
// Optional build macro: BIST_SEQ_LATENCY_EN
//   defined   -> last_phase_cycles reports the LAUNCH-to-completion cycle
//                count of the most recent phase
//   undefined -> last_phase_cycles is tied to 0
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   session_start      one-cycle request, accepted only in IDLE
//   abort              ends a running session (through DONE)
//   phase_mask         enabled phases, latched at start
//   repeat_cfg         list iterations (0 counts as 1), latched at start
//   test_done          STRAIT test_done
//   fail_flags         STRAIT fail indication, bit p belongs to phase p
//   strait_test_mode   STRAIT test_mode
//   strait_start       STRAIT START, one-cycle pulse
//   strait_bist_mode   STRAIT BIST_mode
//   session_busy       high in every non-IDLE state
//   session_done       one-cycle completion pulse
//   session_pass       result, valid from session_done until the next start
//   fail_vector        sticky per-phase fail
//   timeout_flag       sticky, at least one phase timed out
//   abort_flag         session ended by abort
//   cur_phase          phase being run
//   iter_count         completed iterations (saturating)
//   last_phase_cycles  latency of the last phase (optional feature)
//   state_dbg          current FSM state encoding
//
// Handshake: session_start is a single-cycle request that is only accepted
// when session_busy is low (and abort is low); the session then answers with
// exactly one session_done pulse, after which session_pass and the flags hold
// until the next accepted request.
// ---------------------------------------------------------------------------
module bist_session_sequencer #(
    parameter int NUM_PHASES     = 2,
    parameter int MODE_WIDTH     = 1,
    parameter logic [NUM_PHASES*MODE_WIDTH-1:0] PHASE_MODES = {1'b1, 1'b0},
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int REPEAT_WIDTH   = 4,
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1),
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    session_start,
    input  logic                    abort,
    input  logic [NUM_PHASES-1:0]   phase_mask,
    input  logic [REPEAT_WIDTH-1:0] repeat_cfg,
    input  logic                    test_done,
    input  logic [NUM_PHASES-1:0]   fail_flags,
    output logic                    strait_test_mode,
    output logic                    strait_start,
    output logic [MODE_WIDTH-1:0]   strait_bist_mode,
    output logic                    session_busy,
    output logic                    session_done,
    output logic                    session_pass,
    output logic [NUM_PHASES-1:0]   fail_vector,
    output logic                    timeout_flag,
    output logic                    abort_flag,
    output logic [PH_W-1:0]         cur_phase,
    output logic [REPEAT_WIDTH-1:0] iter_count,
    output logic [TO_W-1:0]         last_phase_cycles,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // With no gap configured the phase goes straight to LAUNCH.
    localparam state_t FIRST_STATE = (GAP_CYCLES == 0) ? S_LAUNCH : S_GAP;

    state_t                  state, state_next;
    logic [NUM_PHASES-1:0]   mask_q;
    logic [REPEAT_WIDTH-1:0] rep_q;
    logic [7:0]              gap_cnt;
    logic [TO_W-1:0]         wd_cnt;
    logic                    td_prev;
    logic [MODE_WIDTH-1:0]   mode_q;
    logic                    pass_q;

    logic                    active, accept, aborting, rise, wd_expired, gap_last;
    logic                    has_next, pass_now;
    logic [PH_W-1:0]         next_phase;
    logic [REPEAT_WIDTH-1:0] iter_inc, eff_rep;
    logic [MODE_WIDTH-1:0]   phase_mode;

    function automatic logic [PH_W-1:0] lowest_phase(input logic [NUM_PHASES-1:0] m);
        lowest_phase = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (m[i]) lowest_phase = PH_W'(i);
        end
    endfunction

    assign active     = (state == S_GAP) || (state == S_LAUNCH) ||
                        (state == S_WAIT) || (state == S_RECORD);
    assign accept     = (state == S_IDLE) && session_start && !abort;
    assign aborting   = active && abort;
    // Only a fresh edge completes a phase; a level left over from the
    // previous phase must not.
    assign rise       = test_done && !td_prev;
    assign wd_expired = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign gap_last   = (gap_cnt == 8'(GAP_CYCLES - 1));
    assign iter_inc   = (iter_count == '1) ? iter_count : iter_count + 1'b1;
    assign eff_rep    = (rep_q == '0) ? REPEAT_WIDTH'(1) : rep_q;
    assign pass_now   = ~|fail_vector & ~timeout_flag & ~abort_flag;
    assign phase_mode = PHASE_MODES[int'(cur_phase) * MODE_WIDTH +: MODE_WIDTH];
    assign state_dbg  = state;

    always_comb begin
        has_next   = 1'b0;
        next_phase = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_phase))) begin
                has_next   = 1'b1;
                next_phase = PH_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state and outputs
    always_comb begin
        state_next       = state;
        strait_test_mode = active;
        strait_start     = (state == S_LAUNCH) && !abort;
        strait_bist_mode = active ? phase_mode : mode_q;
        session_busy     = (state != S_IDLE);
        session_done     = (state == S_DONE);
        session_pass     = (state == S_DONE) ? pass_now : pass_q;
        case (state)
            S_IDLE:   if (accept) state_next = (|phase_mask) ? FIRST_STATE : S_DONE;
            S_GAP:    if (gap_last) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (rise || wd_expired) state_next = S_RECORD;
            S_RECORD: begin
                if (has_next)                  state_next = FIRST_STATE;
                else if (iter_inc == eff_rep)  state_next = S_DONE;
                else                           state_next = FIRST_STATE;
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (aborting) state_next = S_DONE;
    end

    // Session datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q       <= '0;
            rep_q        <= '0;
            gap_cnt      <= '0;
            wd_cnt       <= '0;
            td_prev      <= 1'b0;
            mode_q       <= '0;
            pass_q       <= 1'b0;
            fail_vector  <= '0;
            timeout_flag <= 1'b0;
            abort_flag   <= 1'b0;
            cur_phase    <= '0;
            iter_count   <= '0;
        end else begin
            td_prev <= test_done;
            if (active) mode_q <= phase_mode;
            if (aborting) begin
                // Nothing else is recorded in the abort cycle.
                abort_flag <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        mask_q       <= phase_mask;
                        rep_q        <= repeat_cfg;
                        fail_vector  <= '0;
                        timeout_flag <= 1'b0;
                        abort_flag   <= 1'b0;
                        iter_count   <= '0;
                        pass_q       <= 1'b0;
                        gap_cnt      <= '0;
                        cur_phase    <= lowest_phase(phase_mask);
                    end
                    S_GAP:    gap_cnt <= gap_cnt + 1'b1;
                    S_LAUNCH: wd_cnt  <= '0;
                    S_WAIT: begin
                        // A completion edge wins over a same-cycle timeout.
                        if (rise) begin
                            fail_vector[cur_phase] <= fail_vector[cur_phase] | fail_flags[cur_phase];
                        end else if (wd_expired) begin
                            fail_vector[cur_phase] <= 1'b1;
                            timeout_flag           <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    S_RECORD: begin
                        gap_cnt <= '0;
                        if (has_next) begin
                            cur_phase <= next_phase;
                        end else begin
                            iter_count <= iter_inc;
                            if (iter_inc != eff_rep) cur_phase <= lowest_phase(mask_q);
                        end
                    end
                    S_DONE:  pass_q <= pass_now;
                    default: ;
                endcase
            end
        end
    end

`ifdef BIST_SEQ_LATENCY_EN
    logic [TO_W-1:0] lat_cnt;
    logic            lat_to;
    logic [TO_W-1:0] last_q;

    // LAUNCH counts as cycle 1; every WAIT_DONE cycle, including the
    // completing one, adds one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
            lat_to  <= 1'b0;
            last_q  <= '0;
        end else if (accept) begin
            last_q <= '0;
        end else begin
            case (state)
                S_LAUNCH: begin
                    lat_cnt <= TO_W'(1);
                    lat_to  <= 1'b0;
                end
                S_WAIT: begin
                    if (!rise && wd_expired) lat_to  <= 1'b1;
                    else if (lat_cnt != '1)  lat_cnt <= lat_cnt + 1'b1;
                end
                S_RECORD: last_q <= lat_to ? TO_W'(TIMEOUT_CYCLES) : lat_cnt;
                default: ;
            endcase
        end
    end

    assign last_phase_cycles = last_q;
`else
    assign last_phase_cycles = '0;
`endif

endmodule
